// File: rtl/bram_test_pkg.sv
// bram_test_pkg: shared defaults, FSM states and the write-side test pattern for the BRAM self-test.
package bram_test_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  // Callers truncate the result to their data width.
  function automatic logic [63:0] exp_pattern(input logic [63:0] addr);
    return addr << 1;
  endfunction
endpackage

// File: rtl/bram_lat_pipe.sv
// bram_lat_pipe: valid+address delay line matching the BRAM read latency, with synchronous flush.
module bram_lat_pipe #(
  parameter int ADDR_W = 10,
  parameter int LAT = 2
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);
  logic [LAT-1:0] v;
  logic [ADDR_W-1:0] a [LAT];
  always_ff @(posedge clk_100mhz) begin
    if (reset || flush) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) a[i] <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        v[i] <= v[i-1];
        a[i] <= a[i-1];
      end
      v[0] <= in_valid;
      a[0] <= in_addr;
    end
  end
  assign out_valid = v[LAT-1];
  assign out_addr  = a[LAT-1];
endmodule

// File: rtl/bram_read_checker.sv
// bram_read_checker: latency-aligned compare of BRAM read data against the addr<<1 pattern.
// Define BRAM_CHECKER_ERR_CAPTURE_EN to add first-mismatch capture outputs.
module bram_read_checker import bram_test_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LATENCY = 2,
  parameter int NUM_WORDS = 1024,
  parameter int CNT_W = 16
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  input  logic              enable,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  err_count
`ifdef BRAM_CHECKER_ERR_CAPTURE_EN
  ,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
`endif
);
  state_t state, state_nxt;
  logic pv, start, abort, cmp, mism, last;
  logic [ADDR_W-1:0] pa;
  logic [DATA_W-1:0] exp_data;
  logic [CNT_W-1:0] remaining;
  assign start    = state == IDLE && enable;
  assign abort    = state == CHECK && !enable;
  assign cmp      = pv && state == CHECK && enable;
  assign exp_data = DATA_W'(exp_pattern(64'(pa)));
  assign mism     = rd_data != exp_data;
  assign last     = cmp && remaining == CNT_W'(1);
  bram_lat_pipe #(.ADDR_W(ADDR_W), .LAT(RD_LATENCY)) u_pipe (
    .clk_100mhz(clk_100mhz),
    .reset(reset),
    .flush(abort),
    .in_valid(rd_valid),
    .in_addr(rd_addr),
    .out_valid(pv),
    .out_addr(pa)
  );
  always_ff @(posedge clk_100mhz) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (enable ? CHECK : IDLE)
              : !enable ? IDLE
              : last ? DONE
              : state;
  end
  always_comb begin
    busy = state == CHECK;
  end
  // Counters saturate; the final compare is folded into pass as it lands.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      match_count <= '0;
      err_count   <= '0;
      remaining   <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else if (start) begin
      match_count <= '0;
      err_count   <= '0;
      remaining   <= CNT_W'(NUM_WORDS);
      done        <= 1'b0;
      pass        <= 1'b0;
    end else if (cmp) begin
      if (mism) err_count <= err_count + CNT_W'(err_count != '1);
      else match_count <= match_count + CNT_W'(match_count != '1);
      remaining <= remaining - CNT_W'(1);
      if (last) begin
        done <= 1'b1;
        pass <= err_count == '0 && !mism;
      end
    end
  end
`ifdef BRAM_CHECKER_ERR_CAPTURE_EN
  always_ff @(posedge clk_100mhz) begin
    if (reset || start) begin
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_data  <= '0;
    end else if (cmp && mism && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_addr  <= pa;
      first_err_data  <= rd_data;
    end
  end
`endif
endmodule

// File: tb/tb_bram_read_checker.sv
// tb_bram_read_checker: directed vectors over four checker configurations sharing one BRAM model.
module tb_bram_read_checker;
  logic clk_100mhz = 1'b0;
  logic reset, enable, rd_valid;
  logic [9:0] rd_addr, m1, m2, corrupt_addr;
  logic [31:0] rd_data;
  logic corrupt_en, corrupt_all;
  logic busy [4], done [4], pass [4];
  logic [15:0] mc [3], ec [3];
  logic [3:0] mc_d, ec_d;
  logic fe_v [4];
  logic [9:0] fe_a [4];
  logic [31:0] fe_d [4];
  int n_vec = 0, n_err = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) begin
    m1 <= rd_addr;
    m2 <= m1;
  end
  always_comb begin
    rd_data = {22'b0, m2} << 1;
    if (corrupt_all) rd_data = ~({22'b0, m2} << 1);
    else if (corrupt_en && m2 == corrupt_addr) rd_data = 32'h0000DEAD;
  end

`ifdef BRAM_CHECKER_ERR_CAPTURE_EN
  `define CAP(k) , .first_err_valid(fe_v[k]), .first_err_addr(fe_a[k]), .first_err_data(fe_d[k])
`else
  `define CAP(k)
`endif

  bram_read_checker u_a (.clk_100mhz(clk_100mhz), .reset(reset), .enable(enable), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .match_count(mc[0]), .err_count(ec[0]) `CAP(0));
  bram_read_checker #(.NUM_WORDS(16)) u_b (.clk_100mhz(clk_100mhz), .reset(reset), .enable(enable),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .match_count(mc[1]), .err_count(ec[1]) `CAP(1));
  bram_read_checker #(.NUM_WORDS(8)) u_c (.clk_100mhz(clk_100mhz), .reset(reset), .enable(enable),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .match_count(mc[2]), .err_count(ec[2]) `CAP(2));
  bram_read_checker #(.NUM_WORDS(15), .CNT_W(4)) u_d (.clk_100mhz(clk_100mhz), .reset(reset),
    .enable(enable), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy[3]),
    .done(done[3]), .pass(pass[3]), .match_count(mc_d), .err_count(ec_d) `CAP(3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_100mhz);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    rd_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
  endtask

  task automatic issue(input int start, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        rd_valid = 1'b0;
        repeat (gap - 1) tick();
      end
      rd_valid = 1'b1;
      rd_addr = 10'(start + i);
      tick();
    end
    rd_valid = 1'b0;
  endtask

  initial begin
    rd_addr = '0;
    corrupt_en = 1'b0;
    corrupt_all = 1'b0;
    corrupt_addr = 10'd5;
    do_reset();
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_pass", pass[0], 0);
    check("rst_match", mc[0], 0);
    check("rst_err", ec[0], 0);
    // clean 1024-word run
    start_run();
    check("clean_busy", busy[0], 1);
    issue(0, 1024, 1);
    tick();
    check("clean_done_early", done[0], 0);
    check("clean_match_early", mc[0], 1023);
    tick();
    check("clean_done", done[0], 1);
    check("clean_pass", pass[0], 1);
    check("clean_match", mc[0], 1024);
    check("clean_err", ec[0], 0);
    check("clean_busy_low", busy[0], 0);
    // single corruption at addr 5
    do_reset();
    corrupt_en = 1'b1;
    start_run();
    issue(0, 1024, 1);
    repeat (2) tick();
    check("corr_done", done[0], 1);
    check("corr_pass", pass[0], 0);
    check("corr_match", mc[0], 1023);
    check("corr_err", ec[0], 1);
`ifdef BRAM_CHECKER_ERR_CAPTURE_EN
    check("corr_fe_valid", fe_v[0], 1);
    check("corr_fe_addr", fe_a[0], 5);
    check("corr_fe_data", fe_d[0], 32'h0000DEAD);
`endif
    corrupt_en = 1'b0;
    // gapped valid, 16 words
    do_reset();
    start_run();
    issue(0, 16, 3);
    tick();
    check("gap_done_early", done[1], 0);
    check("gap_match_early", mc[1], 15);
    tick();
    check("gap_done", done[1], 1);
    check("gap_match", mc[1], 16);
    check("gap_err", ec[1], 0);
    // address wrap 1020..3
    do_reset();
    start_run();
    issue(1020, 8, 1);
    repeat (2) tick();
    check("wrap_done", done[2], 1);
    check("wrap_pass", pass[2], 1);
    check("wrap_match", mc[2], 8);
    // enable drop after 100 compares with two reads still in flight
    do_reset();
    start_run();
    issue(0, 102, 1);
    check("drop_match_pre", mc[0], 100);
    enable = 1'b0;
    tick();
    check("drop_busy", busy[0], 0);
    check("drop_done", done[0], 0);
    repeat (3) tick();
    check("drop_match", mc[0], 100);
    check("drop_err", ec[0], 0);
    start_run();
    check("reen_match_clr", mc[0], 0);
    issue(0, 1024, 1);
    repeat (2) tick();
    check("reen_done", done[0], 1);
    check("reen_pass", pass[0], 1);
    check("reen_match", mc[0], 1024);
    // saturation: every compare wrong on a 4-bit counter
    do_reset();
    corrupt_all = 1'b1;
    start_run();
    issue(0, 20, 1);
    repeat (2) tick();
    check("sat_err", ec_d, 15);
    check("sat_done", done[3], 1);
    check("sat_pass", pass[3], 0);
    repeat (4) tick();
    check("sat_err_hold", ec_d, 15);
    check("sat_match", mc_d, 0);
    corrupt_all = 1'b0;
    // reset mid-CHECK
    do_reset();
    corrupt_en = 1'b1;
    start_run();
    issue(0, 50, 1);
    check("mid_err_pre", ec[0], 1);
    reset = 1'b1;
    tick();
    check("mid_busy", busy[0], 0);
    check("mid_done", done[0], 0);
    check("mid_pass", pass[0], 0);
    check("mid_match", mc[0], 0);
    check("mid_err", ec[0], 0);
`ifdef BRAM_CHECKER_ERR_CAPTURE_EN
    check("mid_fe_valid", fe_v[0], 0);
`endif
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
